trap_ctrl: RTL

Core-local trap controller for the machine-mode trap path. It detects ecall/ebreak/mret from the execute stage and timer/external interrupts. It sequences the mepc/mstatus/mcause updates through the CSR file's secondary write port, then redirects the PC to the trap vector or back to mepc. It sits beside the execute unit: it consumes mtvec/mepc/mstatus/mie from the CSR file and drives its clint write port.

---
 rtl/trap_ctrl_pkg.sv | 45 ++++
 rtl/trap_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the machine-mode trap controller: CSR addresses, cause codes,
// mstatus/mie bit positions, FSM state encoding and mstatus rewrite helpers.
package trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_EXT    = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_ECALL  = 32'h0000_000B;
  localparam logic [31:0] CAUSE_EBREAK = 32'h0000_0003;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MTIE     = 7;
  localparam int MIE_MEIE     = 11;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE         = 3'd0;
  localparam state_t ST_SAVE_MEPC    = 3'd1;
  localparam state_t ST_SAVE_MSTATUS = 3'd2;
  localparam state_t ST_SAVE_MCAUSE  = 3'd3;
  localparam state_t ST_TRAP_JUMP    = 3'd4;
  localparam state_t ST_MRET_MSTATUS = 3'd5;
  localparam state_t ST_MRET_JUMP    = 3'd6;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    return r;
  endfunction

  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r               = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: detects traps/mret in execute, sequences the
// mepc/mstatus/mcause writes over the secondary CSR port and redirects the PC.
module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter bit VECTORED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid_i,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_ecall_i,
  input  logic        inst_ebreak_i,
  input  logic        inst_mret_i,
  input  logic        irq_timer_i,
  input  logic        irq_ext_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic [31:0] mie_i,
  output logic        csr_we_o,
  output logic [31:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;

  logic        irq_ext_pend;
  logic        irq_tmr_pend;
  logic        event_det;
  logic [31:0] trap_base;
  logic        unused_ok;

  assign irq_ext_pend = mstatus_i[MSTATUS_MIE] & irq_ext_i   & mie_i[MIE_MEIE];
  assign irq_tmr_pend = mstatus_i[MSTATUS_MIE] & irq_timer_i & mie_i[MIE_MTIE];
  assign event_det    = inst_valid_i &
                        (irq_ext_pend | irq_tmr_pend | inst_ecall_i | inst_ebreak_i | inst_mret_i);
  assign trap_base    = {mtvec_i[31:2], 2'b00};
  assign unused_ok    = ^{mie_i[31:12], mie_i[10:8], mie_i[6:0]};

  // Event selection and sequence progression
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cause_d = cause_q;
    case (state_q)
      ST_IDLE: begin
        if (!inst_valid_i) begin
          state_d = ST_IDLE;
        end else if (irq_ext_pend) begin
          state_d = ST_SAVE_MEPC;
          pc_d    = inst_addr_i;
          cause_d = CAUSE_EXT;
        end else if (irq_tmr_pend) begin
          state_d = ST_SAVE_MEPC;
          pc_d    = inst_addr_i;
          cause_d = CAUSE_TIMER;
        end else if (inst_ecall_i) begin
          state_d = ST_SAVE_MEPC;
          pc_d    = inst_addr_i;
          cause_d = CAUSE_ECALL;
        end else if (inst_ebreak_i) begin
          state_d = ST_SAVE_MEPC;
          pc_d    = inst_addr_i;
          cause_d = CAUSE_EBREAK;
        end else if (inst_mret_i) begin
          state_d = ST_MRET_MSTATUS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SAVE_MEPC:    state_d = ST_SAVE_MSTATUS;
      ST_SAVE_MSTATUS: state_d = ST_SAVE_MCAUSE;
      ST_SAVE_MCAUSE:  state_d = ST_TRAP_JUMP;
      ST_TRAP_JUMP:    state_d = ST_IDLE;
      ST_MRET_MSTATUS: state_d = ST_MRET_JUMP;
      ST_MRET_JUMP:    state_d = ST_IDLE;
      default:         state_d = ST_IDLE;
    endcase
  end

  // State and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= 32'd0;
      cause_q <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
    end
  end

  // Write port and redirect decode; CSR reads reflect the previous cycle's write
  always_comb begin
    csr_we_o     = 1'b0;
    csr_waddr_o  = 32'd0;
    csr_wdata_o  = 32'd0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    stall_o      = (state_q != ST_IDLE) | event_det;
    case (state_q)
      ST_SAVE_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MEPC};
        csr_wdata_o = pc_q;
      end
      ST_SAVE_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = trap_mstatus(mstatus_i);
      end
      ST_SAVE_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MCAUSE};
        csr_wdata_o = cause_q;
      end
      ST_TRAP_JUMP: begin
        int_assert_o = 1'b1;
        if (VECTORED && cause_q[31]) begin
          int_addr_o = trap_base + {26'd0, cause_q[3:0], 2'b00};
        end else begin
          int_addr_o = trap_base;
        end
      end
      ST_MRET_MSTATUS: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = {20'd0, CSR_MSTATUS};
        csr_wdata_o = mret_mstatus(mstatus_i);
      end
      ST_MRET_JUMP: begin
        int_assert_o = 1'b1;
        int_addr_o   = mepc_i;
      end
      default: begin
        csr_we_o = 1'b0;
      end
    endcase
  end

endmodule
